// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and the ALU operation code.
// Optional build macro: RISCV_BNE_EN (branch funct3 001 handled as bne).
module riscv_multicycle_controller (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic [1:0] ALUControl_OP,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       Illegal,
   output logic       Retire,
   output logic [3:0] o_dbg_state
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [1:0] w_alusrca, w_alusrcb, w_resultsrc, w_aluop, w_alu_ctl, w_immsrc;
   logic       w_adrsrc, w_irwrite, w_regwrite, w_memwrite, w_illegal, w_retire;
   logic       w_pcupdate, w_branch, w_br_cond, w_f3_alu_ok, w_f3_br_ok;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
`ifdef RISCV_BNE_EN
      w_f3_br_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);
      w_br_cond   = funct3[0] ? ~Zero : Zero;
`else
      w_f3_br_ok  = (funct3 == 3'b000);
      w_br_cond   = Zero;
`endif
   end

   always_comb begin
      w_next      = r_state;
      w_alusrca   = 2'b00;
      w_alusrcb   = 2'b00;
      w_resultsrc = 2'b00;
      w_aluop     = 2'b00;
      w_adrsrc    = 1'b0;
      w_irwrite   = 1'b0;
      w_regwrite  = 1'b0;
      w_memwrite  = 1'b0;
      w_illegal   = 1'b0;
      w_retire    = 1'b0;
      w_pcupdate  = 1'b0;
      w_branch    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_irwrite   = 1'b1;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
            w_pcupdate  = 1'b1;
            w_next      = S_DECODE;
         end
         S_DECODE: begin
            w_alusrca = 2'b01;
            w_alusrcb = 2'b01;
            w_next    = S_FETCH;
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:   if (w_f3_alu_ok) w_next = S_EXECUTER; else w_illegal = 1'b1;
               OP_I:   if (w_f3_alu_ok) w_next = S_EXECUTEI; else w_illegal = 1'b1;
               OP_BR:  if (w_f3_br_ok)  w_next = S_BEQ;      else w_illegal = 1'b1;
               OP_JAL: w_next = S_JAL;
               default: w_illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
            // op[5] separates sw (0100011) from lw (0000011)
            w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            w_adrsrc = 1'b1;
            w_next   = S_MEMWB;
         end
         S_MEMWB: begin
            w_resultsrc = 2'b01;
            w_regwrite  = 1'b1;
            w_retire    = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEMWRITE: begin
            w_adrsrc   = 1'b1;
            w_memwrite = 1'b1;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
         end
         S_EXECUTER: begin
            w_alusrca = 2'b10;
            w_aluop   = 2'b10;
            w_next    = S_ALUWB;
         end
         S_EXECUTEI: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
            w_aluop   = 2'b10;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
         end
         S_BEQ: begin
            w_alusrca = 2'b10;
            w_aluop   = 2'b01;
            w_branch  = 1'b1;
            w_retire  = 1'b1;
            w_next    = S_FETCH;
         end
         S_JAL: begin
            w_alusrca  = 2'b01;
            w_alusrcb  = 2'b10;
            w_pcupdate = 1'b1;
            w_next     = S_ALUWB;
         end
         default: w_next = S_FETCH;
      endcase
   end

   always_comb begin
      w_alu_ctl = 2'b00;
      case (w_aluop)
         2'b01: w_alu_ctl = 2'b01;
         2'b10: begin
            case (funct3)
               3'b000:  w_alu_ctl = (op[5] & funct7b5) ? 2'b01 : 2'b00;
               3'b110:  w_alu_ctl = 2'b11;
               3'b111:  w_alu_ctl = 2'b10;
               default: w_alu_ctl = 2'b00;
            endcase
         end
         default: w_alu_ctl = 2'b00;
      endcase
   end

   always_comb begin
      w_immsrc = 2'b00;
      case (op)
         OP_SW:   w_immsrc = 2'b01;
         OP_BR:   w_immsrc = 2'b10;
         OP_JAL:  w_immsrc = 2'b11;
         default: w_immsrc = 2'b00;
      endcase
   end

   // Reset forces every output low, so no enable leaks out mid-instruction.
   assign ALUControl_OP = RST ? 2'b00 : w_alu_ctl;
   assign ALUSrcA       = RST ? 2'b00 : w_alusrca;
   assign ALUSrcB       = RST ? 2'b00 : w_alusrcb;
   assign ResultSrc     = RST ? 2'b00 : w_resultsrc;
   assign ImmSrc        = RST ? 2'b00 : w_immsrc;
   assign AdrSrc        = ~RST & w_adrsrc;
   assign IRWrite       = ~RST & w_irwrite;
   assign PCWrite       = ~RST & (w_pcupdate | (w_branch & w_br_cond));
   assign RegWrite      = ~RST & w_regwrite;
   assign MemWrite      = ~RST & w_memwrite;
   assign Illegal       = ~RST & w_illegal;
   assign Retire        = ~RST & w_retire;
   assign o_dbg_state   = RST ? 4'd0 : r_state;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Directed bench for riscv_multicycle_controller: per-instruction vector table
// plus hand sequences for reset, a full lw trace and reset during MEMWRITE.
module tb_riscv_multicycle_controller;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [6:0] op = 7'b0000011;
   logic [2:0] funct3 = 3'b010;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic [1:0] ALUControl_OP, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal, Retire;
   logic [3:0] o_dbg_state;

   int n_pass  = 0;
   int n_total = 0;

   always #5 CLK = ~CLK;

   riscv_multicycle_controller dut (
      .CLK(CLK), .RST(RST), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
      .ALUControl_OP(ALUControl_OP), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Illegal(Illegal),
      .Retire(Retire), .o_dbg_state(o_dbg_state)
   );

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       zero;
      int         lat;
      logic [1:0] imm1;
      logic [1:0] alu2;
      logic       pcw2;
      logic       reg_any;
      logic       mem_any;
      logic       ill_any;
      int         retires;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [16:0] outs();
      return {ALUControl_OP, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
              AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal, Retire};
   endfunction

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic resync();
      RST = 1'b1;
      step();
      RST = 1'b0;
      #1;
   endtask

   // Starts in FETCH (low clock phase), returns in the next FETCH.
   task automatic run_vec(input vec_t v);
      int k = 0;
      int ret = 0;
      logic reg_any = 1'b0, mem_any = 1'b0, ill_any = 1'b0, both = 1'b0;
      logic [1:0] imm1 = 2'b00, alu2 = 2'b00;
      logic pcw2 = 1'b0;
      op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.zero;
      forever begin
         if (k == 1) imm1 = ImmSrc;
         if (k == 2) begin alu2 = ALUControl_OP; pcw2 = PCWrite; end
         if (k > 0 && IRWrite) break;
         reg_any |= RegWrite;
         mem_any |= MemWrite;
         ill_any |= Illegal;
         both    |= Illegal & Retire;
         if (Retire) ret++;
         if (k >= 12) break;
         step();
         k++;
      end
      check({v.name, "_latency"}, k, v.lat);
      check({v.name, "_immsrc"}, imm1, v.imm1);
      check({v.name, "_aluctl"}, alu2, v.alu2);
      check({v.name, "_pcwrite"}, pcw2, v.pcw2);
      check({v.name, "_regwrite"}, reg_any, v.reg_any);
      check({v.name, "_memwrite"}, mem_any, v.mem_any);
      check({v.name, "_illegal"}, ill_any, v.ill_any);
      check({v.name, "_retire"}, ret, v.retires);
      check({v.name, "_ill_ret_overlap"}, both, 1'b0);
      if (k >= 12) resync();
   endtask

   logic [16:0] lw_exp[5];

   initial begin
      //          name     op          f3      f7    z     lat imm    alu    pcw   reg   mem   ill   ret
      vecs[0]  = '{"lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 5, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[1]  = '{"sw",   7'b0100011, 3'b010, 1'b0, 1'b1, 4, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1};
      vecs[2]  = '{"sub",  7'b0110011, 3'b000, 1'b1, 1'b1, 4, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[3]  = '{"add",  7'b0110011, 3'b000, 1'b0, 1'b0, 4, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[4]  = '{"addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[5]  = '{"or",   7'b0110011, 3'b110, 1'b0, 1'b0, 4, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[6]  = '{"andi", 7'b0010011, 3'b111, 1'b0, 1'b1, 4, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[7]  = '{"beq_t",7'b1100011, 3'b000, 1'b0, 1'b1, 3, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[8]  = '{"beq_n",7'b1100011, 3'b000, 1'b0, 1'b0, 3, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[9]  = '{"jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 4, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[10] = '{"lui",  7'b0110111, 3'b000, 1'b0, 1'b0, 2, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 0};
      vecs[11] = '{"r_f3", 7'b0110011, 3'b001, 1'b0, 1'b0, 2, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 0};
      vecs[12] = '{"i_f3", 7'b0010011, 3'b100, 1'b0, 1'b0, 2, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 0};
      vecs[13] = '{"b_f3", 7'b1100011, 3'b100, 1'b0, 1'b1, 2, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 0};
`ifdef RISCV_BNE_EN
      vecs[14] = '{"bne",  7'b1100011, 3'b001, 1'b0, 1'b0, 3, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1};
`else
      vecs[14] = '{"bne",  7'b1100011, 3'b001, 1'b0, 1'b0, 2, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 0};
`endif

      lw_exp[0] = {2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 7'b0110000};
      lw_exp[1] = {2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 7'b0000000};
      lw_exp[2] = {2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 7'b0000000};
      lw_exp[3] = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 7'b1000000};
      lw_exp[4] = {2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 7'b0001001};

      // Reset held for three cycles: everything low.
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("reset_outputs", outs(), 17'd0);
         check("reset_state", o_dbg_state, 4'd0);
      end
      RST = 1'b0;
      #1;
      check("post_reset_irwrite", IRWrite, 1'b1);
      check("post_reset_pcwrite", PCWrite, 1'b1);
      check("post_reset_alusrcb", ALUSrcB, 2'b10);

      // Full lw trace, cycle by cycle.
      op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("lw_trace_c%0d", k), outs(), lw_exp[k]);
         step();
      end
      check("lw_trace_back_to_fetch", IRWrite, 1'b1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset asserted during MEMWRITE.
      op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
      for (int k = 0; k < 3; k++) step();
      check("sw_memwrite_before_reset", MemWrite, 1'b1);
      RST = 1'b1;
      #1;
      check("sw_memwrite_at_reset", MemWrite, 1'b0);
      check("sw_outputs_at_reset", outs(), 17'd0);
      check("sw_state_at_reset", o_dbg_state, 4'd0);
      step();
      RST = 1'b0;
      #1;
      check("sw_after_reset_fetch", {IRWrite, PCWrite, MemWrite}, 3'b110);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/riscv_multicycle_controller.md
# riscv_multicycle_controller

Multi-cycle control FSM for the 32-bit RISC-V datapath: the producer of `ALUControl_OP` and the consumer of `Zero` on the ALU control interface. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects, the register, memory and PC write enables, and the 2-bit ALU operation code.

## Interface
- No parameters.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `op` in 7: opcode from the instruction register (`Instr[6:0]`).
- `funct3` in 3: `Instr[14:12]`.
- `funct7b5` in 1: `Instr[30]`.
- `Zero` in 1: ALU zero flag, valid in the same cycle as `ALUControl_OP`.
- `ALUControl_OP` out 2: 00 add, 01 sub, 10 and, 11 or.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 register A.
- `ALUSrcB` out 2: 00 register B, 01 ImmExt, 10 constant 4.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ImmSrc` out 2: 00 I-type, 01 S-type, 10 B-type, 11 J-type.
- `AdrSrc` out 1: 0 PC, 1 Result.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite` out 1 each: write enables.
- `Illegal` out 1: one-cycle pulse on an unsupported instruction.
- `Retire` out 1: one-cycle pulse in the final state of each completed instruction.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL. Encoding is free; the state register is reset to FETCH.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE: op 0000011/0100011→MEMADR; 0110011→EXECUTER; 0010011→EXECUTEI; 1100011→BEQ; 1101111→JAL; anything else→FETCH with `Illegal`=1.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH.
  - BEQ→FETCH.
  - JAL→ALUWB.
- **Moore outputs per state** (any signal not listed is 0; ALUOp is internal):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1, Retire=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, Retire=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1, Retire=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, Retire=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- **PCWrite** = PCUpdate | (Branch & Zero). This is combinational on `Zero`.
- **ALU decode** (combinational):
  - ALUOp 00→00 (add); ALUOp 01→01 (sub).
  - ALUOp 10: funct3 000→01 if (op[5] & funct7b5), else 00; 110→11; 111→10.
- **ImmSrc** (combinational on op): lw/I-type 00, sw 01, beq 10, jal 11, all other ops 00.
- **Illegal conditions:** R/I-type with funct3 ∉ {000,110,111}, or branch with an unsupported funct3.
  - Detected in DECODE.
  - Response: pulse `Illegal`, go to FETCH, issue no write enables.

## Timing
- While `RST`=1, every output is 0, regardless of state.
- FETCH is active in the first rising edge after `RST` deasserts.
- Latency in cycles (FETCH to return to FETCH):
  - lw 5.
  - sw, R-type, I-type, jal 4.
  - beq 3.
  - illegal 2.
- `op`, `funct3` and `funct7b5` are sampled only from DECODE onward; values present during FETCH are don't-care.
- `Zero` is sampled combinationally in BEQ only.
- `RST` asserted mid-instruction: state → FETCH immediately (async) and outputs → 0. No partial write enable survives the reset edge.
- `Illegal` and `Retire` are never high in the same cycle.

## Configuration
- `RISCV_BNE_EN` defined:
  - Branch with funct3 001 is legal.
  - It uses the BEQ state with PCWrite = PCUpdate | (Branch & ~Zero).
- `RISCV_BNE_EN` undefined: branch funct3 001 is illegal (`Illegal` pulse, 2 cycles).
- In both builds, branch funct3 000 behaves as beq.

## Test plan
- Reset: hold `RST`=1 for 3 cycles → all outputs 0. Release → IRWrite=1, PCWrite=1, ALUSrcB=10 in the next cycle.
- lw: op=0000011 → 5-cycle sequence FETCH..MEMWB. MEMREAD has AdrSrc=1. MEMWB has RegWrite=1, ResultSrc=01, Retire=1.
- R-type sub: op=0110011, funct3=000, funct7b5=1 → EXECUTER ALUControl_OP=01. The same encoding with op=0010011 (addi) → 00. funct3=110 → 11; funct3=111 → 10.
- beq: op=1100011, funct3=000, Zero=1 → PCWrite=1 in BEQ, 3-cycle latency. With Zero=0 → PCWrite=0.
- jal: op=1101111 → JAL has PCWrite=1, ALUSrcA=01, ALUSrcB=10. ALUWB follows with RegWrite=1. 4 cycles total.
- Illegal/reset:
  - op=0110111 → `Illegal`=1 for 1 cycle, no RegWrite or MemWrite, back to FETCH.
  - Asserting `RST` during MEMWRITE → MemWrite drops in the same cycle.
